// File: rtl/vec_image_load_sequencer.sv
// Image-memory load sequencer: walks a pixel region in LANES-pixel steps, feeds vectors to the VRF write port.
// Latency: start to first vec_valid is 2 cycles; then 1 vector/cycle while vec_ready stays high.
// Backpressure: vec_ready low holds vec_data/vec_index/mem_addr; optional stall counter under VEC_LOAD_STALL_CNT_EN.
module vec_image_load_sequencer #(
    parameter int IMAGE_WIDTH  = 96,
    parameter int IMAGE_HEIGHT = 96,
    parameter int PIX_SIZE     = 8,
    parameter int LANES        = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       base_addr,
    input  logic [11:0]       num_vec,
    output logic [15:0]       mem_addr,
    input  logic [15:0][15:0] mem_rd,
    output logic [15:0][15:0] vec_data,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [11:0]       vec_index,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef VEC_LOAD_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam logic [16:0] PIX_TOTAL = 17'(IMAGE_WIDTH * IMAGE_HEIGHT);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] cur_addr;
    logic [11:0] remaining;
    logic [16:0] end_addr;
    logic        start_ok;
    logic        start_bad;
    logic        load;
    logic        capture;
    logic        finish;
    logic        handshake;
    logic        unused_lanes;

    // Upper lanes and the zero-extension bits of each lane carry nothing we use.
    assign unused_lanes = ^mem_rd;

    assign end_addr  = {1'b0, base_addr} + 17'(num_vec) * 17'(LANES);
    assign handshake = vec_valid && vec_ready;
    assign mem_addr  = cur_addr;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (end_addr > PIX_TOTAL) begin
                        start_bad = 1'b1;
                    end else if (num_vec == 12'd0) begin
                        start_ok  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        start_ok  = 1'b1;
                        load      = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    if (remaining != 12'd0) begin
                        capture = 1'b1;
                    end else begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            vec_data  <= '0;
            vec_valid <= 1'b0;
            vec_index <= '0;
            err       <= 1'b0;
        end else begin
            err <= start_bad;
            if (load) begin
                cur_addr  <= base_addr;
                remaining <= num_vec;
            end
            if (capture) begin
                // Lanes at and above LANES are never written, so they stay at their reset zero.
                for (int i = 0; i < LANES; i++) begin
                    vec_data[i] <= 16'(mem_rd[i][PIX_SIZE-1:0]);
                end
                vec_valid <= 1'b1;
                vec_index <= (state == FETCH) ? 12'd0 : vec_index + 12'd1;
                cur_addr  <= cur_addr + 16'(LANES);
                remaining <= remaining - 12'd1;
            end
            if (finish) begin
                vec_valid <= 1'b0;
            end
        end
    end

`ifdef VEC_LOAD_STALL_CNT_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if (vec_valid && !vec_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_image_load_sequencer.sv
// Scoreboard bench for vec_image_load_sequencer: a region-level model queues expected vectors, a monitor checks them.
module tb_vec_image_load_sequencer;

    localparam int NPIX = 96 * 96;

    logic              CLK = 1'b0;
    logic              reset;
    logic              start;
    logic [15:0]       base_addr;
    logic [11:0]       num_vec;
    logic [15:0]       mem_addr;
    logic [15:0][15:0] mem_rd;
    logic [15:0][15:0] vec_data;
    logic              vec_valid;
    logic              vec_ready;
    logic [11:0]       vec_index;
    logic              busy;
    logic              done;
    logic              err;
`ifdef VEC_LOAD_STALL_CNT_EN
    logic [15:0]       stall_cycles;
`endif

    vec_image_load_sequencer dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_vec   (num_vec),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .vec_data  (vec_data),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_index (vec_index),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef VEC_LOAD_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0]       idx;
        logic [15:0][15:0] data;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   mem_mode = 0;
    int   ready_mode = 0;
    logic ready_manual = 1'b1;
    vec_t exp_q[$];
    int   exp_done = 0;
    int   exp_err = 0;
    logic [15:0][15:0] zero_vec = '0;

    // mode 0: memory[i] = i; mode 1: scrambled words whose upper byte must be discarded
    function automatic logic [15:0] memword(input logic [15:0] a, input int mode);
        if (mode == 0) return a;
        return (a * 16'd40503) ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] pixel(input int a);
        logic [15:0] w;
        w = memword(16'(a), mem_mode);
        return {8'h00, w[7:0]};
    endfunction

    always_comb begin
        for (int j = 0; j < 16; j++) begin
            mem_rd[j] = memword(mem_addr + 16'(j), mem_mode);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [15:0][15:0] act, input logic [15:0][15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            case (ready_mode)
                0:       vec_ready = 1'b1;
                1:       vec_ready = ($urandom_range(0, 3) != 0);
                default: vec_ready = ready_manual;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks stability while stalled.
    logic              hold_pend = 1'b0;
    logic [15:0][15:0] hold_data;
    logic [11:0]       hold_idx;
    initial begin
        vec_t e;
        forever begin
            @(negedge CLK);
            if (reset) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", 32'(vec_valid), 32'd1);
                    check_vec("hold_data", vec_data, hold_data);
                    check("hold_index", 32'(vec_index), 32'(hold_idx));
                end
                if (vec_valid && vec_ready) begin
                    check("vec_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_vec("vec_data", vec_data, e.data);
                        check("vec_index", 32'(vec_index), 32'(e.idx));
                    end
                    hold_pend = 1'b0;
                end else if (vec_valid) begin
                    hold_pend = 1'b1;
                    hold_data = vec_data;
                    hold_idx  = vec_index;
                end else begin
                    hold_pend = 1'b0;
                end
                if (done) begin
                    check("done_expected", 32'(exp_done > 0), 32'd1);
                    if (exp_done > 0) exp_done--;
                end
                if (err) begin
                    check("err_expected", 32'(exp_err > 0), 32'd1);
                    if (exp_err > 0) exp_err--;
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy || vec_valid) begin
            @(posedge CLK);
            #1;
            n++;
            if (n > 5000) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: busy=%0b vec_valid=%0b after %0d cycles", busy, vec_valid, n);
                break;
            end
        end
    endtask

    // Issues a start from IDLE and queues what the region rules say must come out.
    task automatic do_start(input int b, input int n);
        vec_t e;
        wait_idle();
        start     = 1'b1;
        base_addr = 16'(b);
        num_vec   = 12'(n);
        if (b + n * 8 > NPIX) begin
            exp_err++;
        end else begin
            for (int k = 0; k < n; k++) begin
                e.idx = 12'(k);
                for (int j = 0; j < 16; j++) begin
                    e.data[j] = (j < 8) ? pixel(b + 8 * k + j) : 16'h0000;
                end
                exp_q.push_back(e);
            end
            exp_done++;
        end
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int b, n, lo;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_vec   = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_vec("rst_vec_data", vec_data, zero_vec);
        check("rst_vec_valid", 32'(vec_valid), 32'd0);
        check("rst_vec_index", 32'(vec_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
`ifdef VEC_LOAD_STALL_CNT_EN
        check("rst_stall", 32'(stall_cycles), 32'd0);
`endif
        reset = 1'b0;

        // Basic 3-vector transfer, ready always high
        mem_mode   = 0;
        ready_mode = 0;
        do_start(0, 3);
        check("t1_fetch_busy", 32'(busy), 32'd1);
        check("t1_fetch_novalid", 32'(vec_valid), 32'd0);
        @(posedge CLK); #1;
        check("t1_first_valid", 32'(vec_valid), 32'd1);
        check("t1_first_index", 32'(vec_index), 32'd0);
        check("t1_lane7", 32'(vec_data[7]), 32'd7);
        check("t1_lane8", 32'(vec_data[8]), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("t1_done", 32'(done), 32'd1);
        check("t1_mem_addr_end", 32'(mem_addr), 32'd24);
        check("t1_valid_off", 32'(vec_valid), 32'd0);
        wait_idle();

        // Stall three cycles on vector 1
        ready_mode   = 2;
        ready_manual = 1'b1;
        do_start(0, 3);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("t2_index_at_stall", 32'(vec_index), 32'd1);
        ready_manual = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("t2_index_held", 32'(vec_index), 32'd1);
        check("t2_valid_held", 32'(vec_valid), 32'd1);
        ready_manual = 1'b1;
        wait_idle();
`ifdef VEC_LOAD_STALL_CNT_EN
        check("t2_stall_cycles", 32'(stall_cycles), 32'd3);
`endif
        ready_mode = 0;

        // Bounds: last legal vector, then one pixel past the end
        do_start(9208, 1);
        @(posedge CLK); #1;
        check("t3_lane0", 32'(vec_data[0]), 32'h00F8);
        wait_idle();
        check("t3_mem_addr", 32'(mem_addr), 32'd9216);
        do_start(9209, 1);
        check("t3_err_pulse", 32'(err), 32'd1);
        check("t3_err_busy", 32'(busy), 32'd0);
        check("t3_err_mem_addr", 32'(mem_addr), 32'd9216);
        @(posedge CLK); #1;
        check("t3_err_cleared", 32'(err), 32'd0);
        check("t3_err_busy2", 32'(busy), 32'd0);

        // Empty transfer
        do_start(100, 0);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_novalid", 32'(vec_valid), 32'd0);
        @(posedge CLK); #1;
        check("t4_busy_off", 32'(busy), 32'd0);
        check("t4_done_off", 32'(done), 32'd0);

        // start pulsed mid-transfer must be ignored
        ready_mode = 1;
        do_start(800, 6);
        repeat (3) @(posedge CLK);
        #1;
        if (busy) begin
            start = 1'b1; base_addr = 16'd9209; num_vec = 12'd1;
            @(posedge CLK); #1;
            start = 1'b0;
        end
        wait_idle();
        check("t5_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset while holding vector 5 of 10
        ready_mode = 0;
        do_start(0, 10);
        repeat (6) @(posedge CLK);
        #1;
        check("t6_index5", 32'(vec_index), 32'd5);
        reset = 1'b1;
        @(posedge CLK); #1;
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        check_vec("t6_vec_data", vec_data, zero_vec);
        check("t6_vec_valid", 32'(vec_valid), 32'd0);
        check("t6_vec_index", 32'(vec_index), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err", 32'(err), 32'd0);
`ifdef VEC_LOAD_STALL_CNT_EN
        check("t6_stall", 32'(stall_cycles), 32'd0);
`endif
        exp_q.delete();
        exp_done = 0;
        reset = 1'b0;
        @(posedge CLK); #1;
        check("t6_no_done", 32'(done), 32'd0);
        do_start(16, 2);
        wait_idle();

        // Randomized transfers with random backpressure and intruding starts
        ready_mode = 1;
        mem_mode   = 1;
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 4) == 0) begin
                lo = NPIX - n * 8;
                b  = lo + $urandom_range(0, 1);
            end else begin
                b = $urandom_range(0, 9000);
            end
            do_start(b, n);
            if ($urandom_range(0, 3) == 0 && busy) begin
                start     = 1'b1;
                base_addr = 16'($urandom_range(0, 9300));
                num_vec   = 12'($urandom_range(0, 20));
                @(posedge CLK); #1;
                start = 1'b0;
            end
        end
        wait_idle();
        repeat (2) @(posedge CLK);
        #1;
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_done_count", 32'(exp_done), 32'd0);
        check("end_err_count", 32'(exp_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
